// File: rtl/ita_cmd_scheduler_pkg.sv
// Shared types for the ITA command scheduler: controller config, step encoding, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ita_cmd_scheduler_pkg;

    localparam int unsigned DefCmdDepth      = 4;
    localparam int unsigned DefLaunchTimeout = 16;
    localparam int unsigned DefIdWidth       = 4;
    localparam int unsigned DefCycWidth      = 32;

    typedef enum logic [1:0] {
        Linear      = 2'd0,
        Attention   = 2'd1,
        Feedforward = 2'd2
    } layer_e;

    // Mirrors ita_controller.step_o; Idle means no layer is executing.
    typedef enum logic [3:0] {
        Idle   = 4'd0,
        Q      = 4'd1,
        K      = 4'd2,
        V      = 4'd3,
        QK     = 4'd4,
        AV     = 4'd5,
        OW     = 4'd6,
        MatMul = 4'd7,
        F1     = 4'd8,
        F2     = 4'd9
    } step_e;

    typedef struct packed {
        logic       start;
        layer_e     layer;
        logic [7:0] eps_mult;
        logic [3:0] right_shift;
        logic [7:0] tile_len;
    } ctrl_t;

    typedef enum logic [2:0] {
        SchedIdle    = 3'd0,
        SchedLaunch  = 3'd1,
        SchedWaitAck = 3'd2,
        SchedRun     = 3'd3,
        SchedReport  = 3'd4
    } sched_state_e;

    // Completion record at the default tag/counter widths.
    typedef struct packed {
        logic [DefIdWidth-1:0]  id;
        logic                   err;
        logic [DefCycWidth-1:0] cycles;
    } sched_done_t;

endpackage

// File: rtl/ita_sync_fifo.sv
// Synchronous FIFO with show-ahead read data and a fill-level output.
// Latency: a pushed word is visible at rdata_o the cycle after the push.
// Backpressure: full_o high stops pushes; pushes while full or pops while empty are ignored.
module ita_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned UsageW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [Width-1:0]  wdata_i,
    input  logic              pop_i,
    output logic [Width-1:0]  rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [UsageW-1:0] usage_q, usage_d;
    logic              push_ok, pop_ok;

    assign full_o  = (usage_q == UsageW'(Depth));
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointer and fill-level next state; pointers wrap naturally since Depth is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   usage_d = usage_q + UsageW'(1);
            2'b01:   usage_d = usage_q - UsageW'(1);
            default: usage_d = usage_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Storage needs no reset: contents are only read behind a valid fill level.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ita_cmd_scheduler.sv
// Queues layer commands and launches them one at a time on ita_controller, returning tagged completions.
// Latency: push into an empty idle scheduler -> start pulse 2 cycles later; one bubble cycle after each done.
// Backpressure: cmd_ready_o low when the queue is full; done record held until done_ready_i.
module ita_cmd_scheduler import ita_cmd_scheduler_pkg::*; #(
    parameter int unsigned CmdDepth      = DefCmdDepth,
    parameter int unsigned IdWidth       = DefIdWidth,
    parameter int unsigned LaunchTimeout = DefLaunchTimeout,
    parameter int unsigned CycWidth      = DefCycWidth,
    localparam int unsigned UsageW       = $clog2(CmdDepth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  ctrl_t               cmd_i,
    input  logic [IdWidth-1:0]  cmd_id_i,
    output ctrl_t               ctrl_o,
    input  step_e               step_i,
    output logic                done_valid_o,
    input  logic                done_ready_i,
    output logic [IdWidth-1:0]  done_id_o,
    output logic                done_err_o,
    output logic [CycWidth-1:0] done_cycles_o,
    output logic [UsageW-1:0]   pending_o,
    output logic                idle_o
);

    localparam int unsigned FifoW = $bits(ctrl_t) + IdWidth;
    localparam int unsigned ToW   = $clog2(LaunchTimeout + 1);

    sched_state_e        state_q, state_d;
    ctrl_t               cfg_q, cfg_d;
    logic [IdWidth-1:0]  id_q, id_d;
    logic [CycWidth-1:0] cnt_q, cnt_d, cnt_inc;
    logic                err_q, err_d;
    logic [ToW-1:0]      wait_q, wait_d;

    logic                fifo_full, fifo_empty, fifo_pop;
    logic [FifoW-1:0]    fifo_rdata;

    ita_sync_fifo #(
        .Width (FifoW),
        .Depth (CmdDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i & ~fifo_full),
        .wdata_i ({cmd_i, cmd_id_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (pending_o)
    );

    // Cycle counter sticks at all-ones instead of wrapping.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CycWidth'(1);

    // Launch FSM: pop in IDLE, pulse start, wait for the controller to leave and return to Idle.
    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wait_d   = wait_q;
        fifo_pop = 1'b0;
        case (state_q)
            SchedIdle: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    {cfg_d, id_d} = fifo_rdata;
                    cfg_d.start   = 1'b0;
                    cnt_d         = '0;
                    err_d         = 1'b0;
                    state_d       = SchedLaunch;
                end
            end
            SchedLaunch: begin
                cnt_d   = cnt_inc;
                wait_d  = '0;
                state_d = SchedWaitAck;
            end
            SchedWaitAck: begin
                cnt_d = cnt_inc;
                if (step_i != Idle) begin
                    state_d = SchedRun;
                end else if (wait_q == ToW'(LaunchTimeout - 1)) begin
                    // Controller never acknowledged (e.g. invalid layer): report failure.
                    err_d   = 1'b1;
                    state_d = SchedReport;
                end else begin
                    wait_d = wait_q + ToW'(1);
                end
            end
            SchedRun: begin
                cnt_d = cnt_inc;
                if (step_i == Idle) begin
                    err_d   = 1'b0;
                    state_d = SchedReport;
                end
            end
            SchedReport: begin
                if (done_ready_i) state_d = SchedIdle;
            end
            default: state_d = SchedIdle;
        endcase
    end

    // State and latched command registers with synchronous reset; a reset drops the in-flight command.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SchedIdle;
            cfg_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // Config stays stable from launch until the next pop; start is high only in LAUNCH.
    always_comb begin
        ctrl_o       = cfg_q;
        ctrl_o.start = (state_q == SchedLaunch);
    end

    assign cmd_ready_o   = ~fifo_full;
    assign done_valid_o  = (state_q == SchedReport);
    assign done_id_o     = id_q;
    assign done_err_o    = err_q;
    assign done_cycles_o = cnt_q;
    assign idle_o        = (state_q == SchedIdle) & fifo_empty;

endmodule
